// File: rtl/data_memory_if.sv
// Bus between a requester and the word-addressed data memory.
interface data_memory_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [31:0]           addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  memread;
   logic                  memwrite;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (
      output addr, write_data, memread, memwrite,
      input  read_data
   );

   modport slave (
      input  addr, write_data, memread, memwrite,
      output read_data
   );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: clocked writes, combinational reads,
// asynchronous clear of every word while rst_n is low.
module data_memory #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_BITS  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   data_memory_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_d;
   logic [ADDR_BITS-1:0]             idx;
   logic                             unused_addr_bits;

   // Upper address bits alias onto the low index.
   assign idx              = bus.addr[ADDR_BITS-1:0];
   assign unused_addr_bits = ^bus.addr[31:ADDR_BITS];

   always_comb begin
      mem_d = mem_q;
      if (bus.memwrite == 1'b1) begin
         mem_d[idx] = bus.write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   // No forwarding: a same-cycle write shows up only after the edge.
   assign bus.read_data = (rst_n && bus.memread) ? mem_q[idx] : '0;
endmodule

// File: tb/tb_data_memory.sv
// Directed-vector bench for data_memory.
module tb_data_memory;
   localparam int unsigned DW = 32;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   data_memory_if #(.DATA_WIDTH(DW)) bus ();

   data_memory #(.DATA_WIDTH(DW), .ADDR_BITS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic read_at(input logic [31:0] a, input string tag,
                          input logic [DW-1:0] exp);
      bus.addr    = a;
      bus.memread = 1'b1;
      #1;
      check_eq(tag, bus.read_data, exp);
   endtask

   task automatic write_at(input logic [31:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      bus.addr       = a;
      bus.write_data = d;
      bus.memwrite   = 1'b1;
      @(posedge clk);
      #1;
      bus.memwrite   = 1'b0;
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      rst_n          = 1'b0;
      bus.addr       = 32'h0;
      bus.write_data = '0;
      bus.memread    = 1'b1;
      bus.memwrite   = 1'b0;
      #1;
      check_eq("rst_read", bus.read_data, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      read_at(32'h1, "post_rst_a1", 32'h0);

      // Write with read disabled, then enable read.
      @(negedge clk);
      bus.addr = 32'h1; bus.write_data = 32'hFFFF_FFFE;
      bus.memread = 1'b0; bus.memwrite = 1'b1;
      @(posedge clk); #1;
      check_eq("rd_off", bus.read_data, 32'h0);
      bus.memwrite = 1'b0;
      read_at(32'h1, "rd_on_a1", 32'hFFFF_FFFE);

      // Same-index read and write: old word before, new word after.
      @(negedge clk);
      bus.addr = 32'h2; bus.write_data = 32'hFFFF_FFFD;
      bus.memread = 1'b1; bus.memwrite = 1'b1;
      #1;
      check_eq("rw_before", bus.read_data, 32'h0);
      @(posedge clk); #1;
      check_eq("rw_after", bus.read_data, 32'hFFFF_FFFD);
      bus.memwrite = 1'b0;

      write_at(32'h4, 32'hFFFF_FFFB);
      write_at(32'h8, 32'hFFFF_FFF7);
      read_at(32'h1,   "a1",   32'hFFFF_FFFE);
      read_at(32'h2,   "a2",   32'hFFFF_FFFD);
      read_at(32'h4,   "a4",   32'hFFFF_FFFB);
      read_at(32'h8,   "a8",   32'hFFFF_FFF7);
      read_at(32'h108, "a108", 32'hFFFF_FFF7);
      read_at(32'h5,   "a5",   32'h0);

      // Read index 1 while writing index 3.
      @(negedge clk);
      bus.addr = 32'h1; bus.memread = 1'b1;
      #1;
      check_eq("indep_before", bus.read_data, 32'hFFFF_FFFE);
      write_at(32'hFFFF_FF03, 32'h1234_5678);
      read_at(32'h3, "alias_wr_a3", 32'h1234_5678);
      read_at(32'h1, "indep_a1",    32'hFFFF_FFFE);

      // Idle cycles with random address/data must not disturb storage.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.addr       = $urandom;
         bus.write_data = $urandom;
         bus.memwrite   = 1'b0;
      end
      @(posedge clk); #1;
      read_at(32'h1, "idle_a1", 32'hFFFF_FFFE);
      read_at(32'h2, "idle_a2", 32'hFFFF_FFFD);
      read_at(32'h3, "idle_a3", 32'h1234_5678);
      read_at(32'h4, "idle_a4", 32'hFFFF_FFFB);
      read_at(32'h8, "idle_a8", 32'hFFFF_FFF7);

      // Reset mid-cycle with a write pending on index 4.
      @(negedge clk);
      bus.addr = 32'h4; bus.write_data = 32'hDEAD_BEEF;
      bus.memread = 1'b1; bus.memwrite = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_a4", bus.read_data, 32'h0);
      @(posedge clk); #1;
      check_eq("rst_blocks_wr", bus.read_data, 32'h0);
      @(negedge clk);
      bus.memwrite = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      read_at(32'h1, "clr_a1", 32'h0);
      read_at(32'h2, "clr_a2", 32'h0);
      read_at(32'h3, "clr_a3", 32'h0);
      read_at(32'h4, "clr_a4", 32'h0);
      read_at(32'h8, "clr_a8", 32'h0);

      // Write held through reset release lands on the first edge after it.
      @(negedge clk);
      rst_n = 1'b0;
      bus.addr = 32'h9; bus.write_data = 32'hA5A5_5A5A; bus.memwrite = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_hold_a9", bus.read_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("release_pre_edge", bus.read_data, 32'h0);
      @(posedge clk); #1;
      bus.memwrite = 1'b0;
      read_at(32'h9, "release_wr_a9", 32'hA5A5_5A5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, word width in bits.
REQ-002 Parameter: ADDR_BITS, default 8, number of address bits used as the word index, giving 2**ADDR_BITS words (256 by default).
REQ-003 Port: clk, input, 1 bit, the single clock; all writes occur on its rising edge.
REQ-004 Port: rst_n, input, 1 bit, reset; asynchronous and active-low.
REQ-005 Port: addr, input, 32 bits, word address; addr[ADDR_BITS-1:0] is the word index.
REQ-006 Port: write_data, input, DATA_WIDTH bits, data to store.
REQ-007 Port: memread, input, 1 bit, read enable.
REQ-008 Port: memwrite, input, 1 bit, write enable.
REQ-009 Port: read_data, output, DATA_WIDTH bits, read result.

Function
REQ-010 Storage SHALL be an array of 2**ADDR_BITS words of DATA_WIDTH bits.
REQ-011 Address decode:
- Word index = addr[ADDR_BITS-1:0].
- addr[31:ADDR_BITS] SHALL be ignored, so aliasing wraps modulo 2**ADDR_BITS.
- Addresses are word indices, not byte addresses; no alignment check.
REQ-012 Write: on a rising clk edge with rst_n=1 and memwrite=1, mem[index] SHALL be loaded with write_data; write latency is one edge.
REQ-013 With memwrite=0, no word SHALL change.
REQ-014 Read (combinational, zero latency):
- memread=1: read_data SHALL equal mem[index].
- memread=0: read_data SHALL be all zeros.
REQ-015 read_data SHALL track changes to addr, memread and stored contents combinationally, with no clock needed.
REQ-016 Simultaneous memread=1 and memwrite=1 to the same index:
- Before the edge, read_data SHALL show the old word.
- After the edge, read_data SHALL show write_data (no bypass/forwarding).
REQ-017 Simultaneous read and write to different indices SHALL be independent.
REQ-018 Inputs X/undriven while memwrite=0 SHALL NOT corrupt storage.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear every memory word to 0, without waiting for a clock edge.
REQ-020 While rst_n=0, writes SHALL be blocked.
REQ-021 While rst_n=0, read_data SHALL be 0 regardless of memread.
REQ-022 Release of rst_n takes effect at the next rising edge; a write asserted on that edge SHALL be performed.
REQ-023 Reset asserted mid-operation SHALL discard any write pending on the current cycle.

Verification
REQ-024 Reset, then memread=1, memwrite=0, addr=0x1 -> read_data=0x00000000.
REQ-025 memwrite=1, memread=0, addr=0x1, write_data=0xFFFFFFFE, one edge -> read_data=0 while memread=0; then set memread=1 -> read_data=0xFFFFFFFE.
REQ-026 memread=1, memwrite=1, addr=0x2, write_data=0xFFFFFFFD -> read_data=0 before the edge and 0xFFFFFFFD after it.
REQ-027 Write 0xFFFFFFFB to 0x4 and 0xFFFFFFF7 to 0x8 (memread=1 during both writes), then read addresses 0x1, 0x2, 0x4, 0x8 and 0x108 -> 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFB, 0xFFFFFFF7, 0xFFFFFFF7 respectively (0x108 aliases 0x8).
REQ-028 Drive rst_n low between clock edges with memwrite=1 pending on addr 0x4 -> read of addr 0x4 returns 0 immediately; after release, all previously written words read 0.
REQ-029 memwrite=0 for 10 cycles with random addr and write_data -> all contents unchanged.
